// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-block game core.
// Holds the piece encodings, the default piece-type count, the LFSR polynomial,
// the default seed, the piece-queue FSM state type and the LFSR step helper.
package tetris_pkg;

   // Piece encodings.
   localparam int unsigned PieceI = 0;
   localparam int unsigned PieceO = 1;
   localparam int unsigned PieceT = 2;
   localparam int unsigned PieceS = 3;
   localparam int unsigned PieceZ = 4;
   localparam int unsigned PieceJ = 5;
   localparam int unsigned PieceL = 6;

   localparam int unsigned NumTypesDefault = 7;

   localparam logic [15:0] LfsrPoly        = 16'hB400;
   localparam logic [15:0] LfsrSeedDefault = 16'hACE1;

   typedef enum logic [0:0] {
      StFill,
      StRun
   } queue_state_e;

   // One step of the 16-bit Galois LFSR: shift right and apply the tap mask
   // whenever a one falls out of the LSB.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LfsrPoly) : (s >> 1);
   endfunction

endpackage

// File: rtl/piece_queue_if.sv
// Handshake bundle between the button logic / playfield controller and piece_queue.
//   advance    : pulse, the current piece has been consumed
//   swap       : pulse, exchange current with the hold slot
//   current    : piece in play
//   preview    : upcoming pieces, slot 0 (next) in the LSBs
//   hold       : held piece, meaningful only with hold_valid
//   hold_valid : hold slot occupied
//   swap_ok    : a swap would be accepted this cycle
//   ready      : queue full, outputs valid
interface piece_queue_if #(
   parameter int unsigned PIECE_W       = 3,
   parameter int unsigned PREVIEW_DEPTH = 3
);
   logic                               advance;
   logic                               swap;
   logic [PIECE_W-1:0]                 current;
   logic [PREVIEW_DEPTH*PIECE_W-1:0]   preview;
   logic [PIECE_W-1:0]                 hold;
   logic                               hold_valid;
   logic                               swap_ok;
   logic                               ready;

   // Controller side: drives the pulses, observes the queue.
   modport master (
      output advance, swap,
      input  current, preview, hold, hold_valid, swap_ok, ready
   );

   // Queue side.
   modport slave (
      input  advance, swap,
      output current, preview, hold, hold_valid, swap_ok, ready
   );
endinterface

// File: rtl/piece_bag_gen.sv
// 7-bag style piece generator: a free-running 16-bit Galois LFSR proposes a
// candidate, the bag mask rejects types already dealt in the current bag.
//   clk, reset_n : clock, asynchronous active-low reset
//   take_i       : shift strobe from the queue; consumes piece_o this cycle
//   piece_o      : piece that enters the queue on the next take
module piece_bag_gen import tetris_pkg::*; #(
   parameter int unsigned NUM_TYPES = NumTypesDefault,
   parameter int unsigned PIECE_W   = 3,
   parameter logic [15:0] SEED      = LfsrSeedDefault
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               take_i,
   output logic [PIECE_W-1:0] piece_o
);

   localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? LfsrSeedDefault : SEED;
   localparam int unsigned PadW    = 1 << PIECE_W;

   logic [15:0]          lfsr_q, lfsr_d;
   logic [NUM_TYPES-1:0] mask_q, mask_d, mask_set;
   logic [PadW-1:0]      mask_pad;
   logic [PIECE_W-1:0]   cand, pick;

   // Encodings beyond NUM_TYPES are padded as "taken" so an out-of-range
   // candidate falls through to the lowest free type.
   always_comb begin
      mask_pad                  = '1;
      mask_pad[NUM_TYPES-1:0]   = mask_q;
      cand                      = lfsr_q[PIECE_W-1:0];
      pick                      = '0;
      if (!mask_pad[cand]) begin
         pick = cand;
      end else begin
         for (int i = NUM_TYPES - 1; i >= 0; i--) begin
            if (!mask_q[i]) pick = PIECE_W'(i);
         end
      end
   end

   // A full bag empties in the same update that fills it.
   always_comb begin
      mask_set = mask_q;
      for (int i = 0; i < NUM_TYPES; i++) begin
         if (PIECE_W'(i) == pick) mask_set[i] = 1'b1;
      end
      mask_d = mask_q;
      if (take_i) mask_d = (&mask_set) ? '0 : mask_set;
      lfsr_d = lfsr_step(lfsr_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q <= SeedEff;
         mask_q <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         mask_q <= mask_d;
      end
   end

   assign piece_o = pick;

endmodule

// File: rtl/piece_queue.sv
// Next-piece queue: current piece plus PREVIEW_DEPTH preview slots fed by
// piece_bag_gen, one hold slot, and a swap lock released by each advance.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : piece_queue_if slave (advance/swap in; current, preview,
//                  hold, hold_valid, swap_ok, ready out)
module piece_queue import tetris_pkg::*; #(
   parameter int unsigned NUM_TYPES     = NumTypesDefault,
   parameter int unsigned PREVIEW_DEPTH = 3,
   parameter logic [15:0] SEED          = LfsrSeedDefault
) (
   input  logic          clk,
   input  logic          reset_n,
   piece_queue_if.slave  bus
);

   localparam int unsigned PIECE_W = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1;
   localparam int unsigned CntW    = (PREVIEW_DEPTH > 0) ? $clog2(PREVIEW_DEPTH + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(PREVIEW_DEPTH);

   queue_state_e       state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [PIECE_W-1:0] queue_q [PREVIEW_DEPTH+1];
   logic [PIECE_W-1:0] queue_d [PREVIEW_DEPTH+1];
   logic [PIECE_W-1:0] hold_q, hold_d;
   logic               hold_valid_q, hold_valid_d;
   logic               swap_used_q, swap_used_d;
   logic               shift;
   logic [PIECE_W-1:0] gen_piece;
   logic               ready, swap_ok;
   logic [PREVIEW_DEPTH*PIECE_W-1:0] preview_flat;

   piece_bag_gen #(
      .NUM_TYPES (NUM_TYPES),
      .PIECE_W   (PIECE_W),
      .SEED      (SEED)
   ) u_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .take_i  (shift),
      .piece_o (gen_piece)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StFill;
      else          state_q <= state_d;
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFill:  if (cnt_q == CntLast) state_d = StRun;
         StRun:   state_d = StRun;
         default: state_d = StFill;
      endcase
   end

   // FSM outputs.
   always_comb begin
      ready   = (state_q == StRun);
      swap_ok = ready & ~swap_used_q;
   end

   // Queue, hold slot and swap lock next state.
   always_comb begin
      shift        = 1'b0;
      cnt_d        = cnt_q;
      queue_d      = queue_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      swap_used_d  = swap_used_q;
      unique case (state_q)
         StFill: begin
            shift = 1'b1;
            if (cnt_q != CntLast) cnt_d = cnt_q + 1'b1;
         end
         StRun: begin
            // advance has priority and drops a coincident swap
            if (bus.advance) begin
               shift       = 1'b1;
               swap_used_d = 1'b0;
            end else if (bus.swap && swap_ok) begin
               swap_used_d = 1'b1;
               hold_d      = queue_q[0];
               if (hold_valid_q) begin
                  queue_d[0] = hold_q;
               end else begin
                  hold_valid_d = 1'b1;
                  shift        = 1'b1;
               end
            end
         end
         default: ;
      endcase
      if (shift) begin
         for (int i = 0; i < PREVIEW_DEPTH; i++) queue_d[i] = queue_q[i+1];
         queue_d[PREVIEW_DEPTH] = gen_piece;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         swap_used_q  <= 1'b0;
         for (int i = 0; i <= PREVIEW_DEPTH; i++) queue_q[i] <= '0;
      end else begin
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         swap_used_q  <= swap_used_d;
         queue_q      <= queue_d;
      end
   end

   always_comb begin
      preview_flat = '0;
      for (int i = 0; i < PREVIEW_DEPTH; i++) begin
         preview_flat[i*PIECE_W +: PIECE_W] = queue_q[i+1];
      end
   end

   assign bus.current    = queue_q[0];
   assign bus.preview    = preview_flat;
   assign bus.hold       = hold_q;
   assign bus.hold_valid = hold_valid_q;
   assign bus.swap_ok    = swap_ok;
   assign bus.ready      = ready;

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue: three instances (default seed, zero seed,
// depth 5 / 5 types); only the selected one is out of reset at a time.
// A cycle model pushes expected outputs into a scoreboard queue each step.
module tb_piece_queue;
   import tetris_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_z, rst_b;
   logic adv, swp;

   piece_queue_if #(.PIECE_W(3), .PREVIEW_DEPTH(3)) if_a ();
   piece_queue_if #(.PIECE_W(3), .PREVIEW_DEPTH(3)) if_z ();
   piece_queue_if #(.PIECE_W(3), .PREVIEW_DEPTH(5)) if_b ();

   assign if_a.advance = adv;
   assign if_a.swap    = swp;
   assign if_z.advance = adv;
   assign if_z.swap    = swp;
   assign if_b.advance = adv;
   assign if_b.swap    = swp;

   piece_queue #(.NUM_TYPES(7), .PREVIEW_DEPTH(3), .SEED(16'hACE1)) dut_a (
      .clk(clk), .reset_n(rst_a), .bus(if_a));
   piece_queue #(.NUM_TYPES(7), .PREVIEW_DEPTH(3), .SEED(16'h0000)) dut_z (
      .clk(clk), .reset_n(rst_z), .bus(if_z));
   piece_queue #(.NUM_TYPES(5), .PREVIEW_DEPTH(5), .SEED(16'hACE1)) dut_b (
      .clk(clk), .reset_n(rst_b), .bus(if_b));

   typedef struct {
      int cur;
      int prev;
      int hold;
      int hv;
      int ok;
      int rdy;
   } exp_t;

   exp_t sb[$];
   int   n_err    = 0;
   int   n_checks = 0;

   // model state
   int          sel, n_types, depth, pw;
   logic [15:0] seed, m_lfsr;
   int          m_mask, m_hold, m_hv, m_used, m_run, m_cnt;
   int          m_q[8];
   int          exp_seq[14];
   int          seqo[14];

   // last observed DUT outputs
   int o_cur, o_prev, o_hold, o_hv, o_ok, o_rdy;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic observe();
      case (sel)
         0: begin
            o_cur = int'(if_a.current); o_prev = int'(if_a.preview); o_hold = int'(if_a.hold);
            o_hv = int'(if_a.hold_valid); o_ok = int'(if_a.swap_ok); o_rdy = int'(if_a.ready);
         end
         1: begin
            o_cur = int'(if_z.current); o_prev = int'(if_z.preview); o_hold = int'(if_z.hold);
            o_hv = int'(if_z.hold_valid); o_ok = int'(if_z.swap_ok); o_rdy = int'(if_z.ready);
         end
         default: begin
            o_cur = int'(if_b.current); o_prev = int'(if_b.preview); o_hold = int'(if_b.hold);
            o_hv = int'(if_b.hold_valid); o_ok = int'(if_b.swap_ok); o_rdy = int'(if_b.ready);
         end
      endcase
   endtask

   task automatic model_reset();
      m_lfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
      m_mask = 0; m_hold = 0; m_hv = 0; m_used = 0; m_run = 0; m_cnt = 0;
      for (int i = 0; i < 8; i++) m_q[i] = 0;
   endtask

   function automatic int model_gen();
      int cand;
      cand = int'(m_lfsr) & ((1 << pw) - 1);
      if (cand < n_types && ((m_mask >> cand) & 1) == 0) return cand;
      for (int i = 0; i < n_types; i++) if (((m_mask >> i) & 1) == 0) return i;
      return 0;
   endfunction

   task automatic model_shift();
      int p;
      p = model_gen();
      for (int i = 0; i < depth; i++) m_q[i] = m_q[i+1];
      m_q[depth] = p;
      m_mask = m_mask | (1 << p);
      if (m_mask == (1 << n_types) - 1) m_mask = 0;
   endtask

   task automatic model_step(input bit a, input bit s);
      int t;
      if (m_run == 0) begin
         model_shift();
         if (m_cnt == depth) m_run = 1;
         else m_cnt++;
      end else if (a) begin
         model_shift();
         m_used = 0;
      end else if (s && m_used == 0) begin
         m_used = 1;
         if (m_hv != 0) begin
            t = m_q[0]; m_q[0] = m_hold; m_hold = t;
         end else begin
            m_hold = m_q[0]; m_hv = 1;
            model_shift();
         end
      end
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
   endtask

   function automatic int model_prev();
      int p;
      p = 0;
      for (int i = 0; i < depth; i++) p = p | (m_q[i+1] << (i * pw));
      return p;
   endfunction

   task automatic cycle(input bit a, input bit s);
      exp_t e;
      adv = a; swp = s;
      model_step(a, s);
      e.cur = m_q[0]; e.prev = model_prev(); e.hold = m_hold;
      e.hv = m_hv; e.ok = (m_run != 0 && m_used == 0) ? 1 : 0; e.rdy = m_run;
      sb.push_back(e);
      @(posedge clk);
      #1;
      adv = 1'b0; swp = 1'b0;
      observe();
      e = sb.pop_front();
      chk("current", o_cur, e.cur);
      chk("preview", o_prev, e.prev);
      chk("hold", o_hold, e.hold);
      chk("hold_valid", o_hv, e.hv);
      chk("swap_ok", o_ok, e.ok);
      chk("ready", o_rdy, e.rdy);
   endtask

   task automatic start(input int s_i, input int n_i, input int d_i, input logic [15:0] seed_i);
      rst_a = 1'b0; rst_z = 1'b0; rst_b = 1'b0;
      sel = s_i; n_types = n_i; depth = d_i; pw = 3; seed = seed_i;
      @(posedge clk);
      #1;
      case (sel)
         0:       rst_a = 1'b1;
         1:       rst_z = 1'b1;
         default: rst_b = 1'b1;
      endcase
      model_reset();
      observe();
      chk("rst_current", o_cur, 0);
      chk("rst_hold_valid", o_hv, 0);
      chk("rst_ready", o_rdy, 0);
      chk("rst_swap_ok", o_ok, 0);
   endtask

   task automatic fill_phase();
      for (int k = 1; k <= depth + 1; k++) begin
         cycle(1'b1, 1'b1);
         chk("fill_ready_edge", o_rdy, (k == depth + 1) ? 1 : 0);
         if (k <= depth) begin
            chk("fill_current", o_cur, 0);
            chk("fill_hold", o_hold, 0);
            chk("fill_hold_valid", o_hv, 0);
            chk("fill_swap_ok", o_ok, 0);
         end
      end
   endtask

   task automatic seq_phase(input int count);
      int m;
      seqo[0] = o_cur;
      if (sel == 0) exp_seq[0] = m_q[0];
      if (sel == 1) chk("seed0_seq", o_cur, exp_seq[0]);
      for (int i = 1; i < count; i++) begin
         cycle(1'b1, 1'b0);
         seqo[i] = o_cur;
         if (sel == 0) exp_seq[i] = m_q[0];
         if (sel == 1) chk("seed0_seq", o_cur, exp_seq[i]);
      end
      for (int g = 0; g + n_types <= count; g += n_types) begin
         m = 0;
         for (int i = 0; i < n_types; i++) begin
            if (seqo[g+i] < n_types) m = m | (1 << seqo[g+i]);
         end
         chk("bag_permutation", m, (1 << n_types) - 1);
      end
   endtask

   task automatic swap_scenario();
      int pa, pb, pc, pv, hh, nx;
      pa = m_q[0]; pb = m_q[1];
      cycle(1'b0, 1'b1);
      chk("swap_empty_hold", o_hold, pa);
      chk("swap_empty_hv", o_hv, 1);
      chk("swap_empty_cur", o_cur, pb);
      chk("swap_empty_ok", o_ok, 0);
      cycle(1'b0, 1'b1);
      chk("swap_locked_hold", o_hold, pa);
      chk("swap_locked_cur", o_cur, pb);
      cycle(1'b1, 1'b0);
      chk("swap_unlock_ok", o_ok, 1);
      pc = m_q[0]; pv = model_prev();
      cycle(1'b0, 1'b1);
      chk("swap_full_cur", o_cur, pa);
      chk("swap_full_hold", o_hold, pc);
      chk("swap_full_preview", o_prev, pv);
      cycle(1'b1, 1'b0);
      hh = m_hold; nx = m_q[1];
      cycle(1'b1, 1'b1);
      chk("adv_swap_cur", o_cur, nx);
      chk("adv_swap_hold", o_hold, hh);
      chk("adv_swap_ok", o_ok, 1);
   endtask

   initial begin
      adv = 1'b0; swp = 1'b0;
      rst_a = 1'b0; rst_z = 1'b0; rst_b = 1'b0;

      // default parameters, SEED 16'hACE1
      start(0, 7, 3, 16'hACE1);
      fill_phase();
      seq_phase(14);
      swap_scenario();

      // one-cycle reset pulse mid-RUN with the hold slot occupied
      rst_a = 1'b0;
      #1;
      observe();
      chk("midrst_current", o_cur, 0);
      chk("midrst_preview", o_prev, 0);
      chk("midrst_hold", o_hold, 0);
      chk("midrst_hold_valid", o_hv, 0);
      chk("midrst_swap_ok", o_ok, 0);
      chk("midrst_ready", o_rdy, 0);
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      model_reset();
      fill_phase();
      for (int i = 1; i < 8; i++) begin
         cycle(1'b1, 1'b0);
         chk("midrst_seq", o_cur, exp_seq[i]);
      end

      // SEED 0 must behave exactly like the default seed
      start(1, 7, 3, 16'h0000);
      fill_phase();
      seq_phase(14);

      // five types, five preview slots
      start(2, 5, 5, 16'hACE1);
      fill_phase();
      seq_phase(10);
      swap_scenario();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/piece_queue.md
# piece_queue

Parametrised next-piece queue for the falling-block game core. It generates pieces with a 7-bag randomizer and keeps a current piece plus a configurable-depth preview. It also holds one reserved piece, with a once-per-drop swap lock. It sits between the debounced/edge-detected button logic and the playfield controller, which consumes `current` and pulses `advance` when a piece locks.

## Interface

Parameters:

- `NUM_TYPES`, 7, number of distinct piece types; encodings are 0..NUM_TYPES-1.
- `PREVIEW_DEPTH`, 3, number of preview entries after `current` (≥1).
- `SEED`, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.
- Localparam `PIECE_W` = clog2(NUM_TYPES), minimum 1.

Ports:

- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `advance`  in  1  single-cycle pulse: the current piece has been consumed.
- `swap`  in  1  single-cycle pulse: exchange the current piece with the hold slot.
- `current`  out  PIECE_W  piece in play.
- `preview`  out  PREVIEW_DEPTH*PIECE_W  upcoming pieces; slot 0 (next) is in the LSBs.
- `hold`  out  PIECE_W  held piece; valid only when `hold_valid`.
- `hold_valid`  out  1  the hold slot is occupied.
- `swap_ok`  out  1  a swap will be accepted this cycle.
- `ready`  out  1  the queue is full and outputs are valid.

## Operation

- Reset values: all outputs are 0. The bag mask is cleared and the LFSR is loaded with `SEED`. The FSM enters FILL.
- LFSR: 16-bit Galois, polynomial mask 16'hB400, steps every cycle in every state.
- Generator, combinational:
  - candidate = lfsr[PIECE_W-1:0].
  - If candidate < NUM_TYPES and its bag bit is clear, the candidate is accepted.
  - Otherwise the lowest-index type with a clear bag bit is output.
  - On every queue shift, the output type's bag bit is set. If that makes the mask all ones, the mask is cleared in the same update.
  - Result: every aligned group of NUM_TYPES generated pieces is a permutation.
- Queue: NUM_TYPES-agnostic shift register of PREVIEW_DEPTH+1 entries, ordered current, preview[0..D-1].
  - A shift moves every entry one slot toward current.
  - The generator output enters the last preview slot.
- FSM states:
  - FILL: shifts every cycle. A counter runs 0..PREVIEW_DEPTH. When the counter reaches PREVIEW_DEPTH, the FSM moves to RUN. `ready`=0, `swap_ok`=0, and `advance`/`swap` are ignored.
  - RUN: `ready`=1.
    - `advance`: shift the queue and clear `swap_used`.
    - `swap` while `swap_ok`, hold empty: hold←current, `hold_valid`←1, shift the queue, `swap_used`←1.
    - `swap` while `swap_ok`, hold full: exchange current and hold with no shift; `swap_used`←1.
    - `swap` while not `swap_ok`: ignored.
- `swap_ok` = RUN & ~`swap_used`.
- Simultaneous `advance` and `swap`: `advance` wins, `swap` is dropped, and `swap_used` is cleared.
- Reset mid-operation: asynchronous return to the reset values. Hold contents are lost.

## Timing

- All outputs are registered. A pulse sampled at edge n is visible after edge n (one-cycle latency).
- `ready` rises at edge PREVIEW_DEPTH+1 after reset deassertion (4 edges for the defaults).
- Sustained `advance` every cycle is supported; the generator supplies one piece per cycle with no stall.
- Inputs must be synchronous single-cycle pulses. A level held high acts as repeated pulses; the `swap` lock still limits swaps to one per drop.

## Structure

- Shared package `tetris_pkg`:
  - Piece encoding constants: I=0, O=1, T=2, S=3, Z=4, J=5, L=6.
  - Default NUM_TYPES.
  - LFSR polynomial and default seed.
- Sub-module `piece_bag_gen`:
  - Contains the LFSR, bag mask and generator.
  - Ports: `clk`, `reset_n`, `take` in, `piece` out.
  - `take` is the shift strobe from the queue.
- The queue shift register, hold slot, FSM and swap lock live in `piece_queue`.

## Test plan

- Reset release, default params, SEED=16'hACE1: `ready`=0 for 3 edges and 1 from the 4th. `current`, `hold`, `hold_valid` and `swap_ok` are 0 during FILL.
- Issue 14 `advance` pulses after `ready` and record the `current` sequence. Each of pieces 1–7 and 8–14 is a permutation of {0..6}. Repeat with SEED=0 and confirm the sequence is identical to SEED=16'hACE1.
- Empty-hold swap with current=A and preview[0]=B: after the edge, hold=A, `hold_valid`=1, current=B, `swap_ok`=0. A second `swap` leaves all state unchanged. The next `advance` sets `swap_ok`=1.
- Full-hold swap with hold=A and current=C: after the edge, current=A, hold=C, and all preview slots are unchanged.
- Simultaneous `advance`+`swap` with `swap_ok`=1: the queue shifts once, hold is unchanged, and `swap_ok` stays 1.
- Assert `reset_n` for 1 cycle mid-RUN with the hold occupied: all outputs go to 0 immediately, the FSM refills, and `ready` returns after 4 edges with the same sequence as from cold reset.
- Repeat the swap and sequence scenarios with PREVIEW_DEPTH=5 and NUM_TYPES=5: each group of 5 is a permutation of {0..4}, and `ready` rises at the 6th edge.
